// File: rtl/jump_redirect_unit.sv
// ============================================================================
// Module      : jump_redirect_unit
// Description : PC sequencer with one-delay-slot jump/branch redirect and halt.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jump_redirect_unit #(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic [1:0]        jtype,
    input  logic [25:0]       j_immdt,
    input  logic [15:0]       br_offset,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] rs_value,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              in_delay_slot,
    output logic              halted,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DELAY = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] c_JT_NONE   = 2'd0;
    localparam logic [1:0] c_JT_J      = 2'd1;
    localparam logic [1:0] c_JT_JR     = 2'd2;
    localparam logic [1:0] c_JT_BRANCH = 2'd3;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_j_target;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_target;
    logic              w_redirect;

    assign w_pc4       = pc_q + ADDR_W'(4);
    assign w_br_target = w_pc4 + {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};

    // A 28-bit PC has no region bits above the 26-bit immediate field.
    generate
        if (ADDR_W > 28) begin : g_j_region
            assign w_j_target = {w_pc4[ADDR_W-1:28], j_immdt, 2'b00};
        end else begin : g_j_flat
            assign w_j_target = {j_immdt, 2'b00};
        end
    endgenerate

    always_comb begin
        w_target   = w_pc4;
        w_redirect = 1'b0;
        case (jtype)
            c_JT_J: begin
                w_target   = w_j_target;
                w_redirect = 1'b1;
            end
            c_JT_JR: begin
                w_target   = rs_value;
                w_redirect = 1'b1;
            end
            c_JT_BRANCH: begin
                w_target   = w_br_target;
                w_redirect = br_taken;
            end
            default: begin
                w_target   = w_pc4;
                w_redirect = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        addr_err_d = addr_err_q;
        case (state_q)
            RUN: begin
                if (advance) begin
                    if (jtype == c_JT_JR && rs_value[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                        state_d    = HALT;
                    end else if (w_redirect) begin
                        target_d = w_target;
                        pc_d     = w_pc4;
                        state_d  = DELAY;
                    end else begin
                        pc_d = w_pc4;
                    end
                end
            end
            DELAY: begin
                // A zero target is the halt request; jumps in the slot are ignored.
                if (advance) begin
                    if (target_q == '0) begin
                        pc_d    = '0;
                        state_d = HALT;
                    end else begin
                        pc_d    = target_q;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR[ADDR_W-1:0];
            target_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pc            = pc_q;
    assign link_addr     = pc_q + ADDR_W'(8);
    assign in_delay_slot = (state_q == DELAY);
    assign halted        = (state_q == HALT);
    assign addr_err      = addr_err_q;

endmodule

`default_nettype wire
